// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock/tick divider.
package clk_div_pkg;

  localparam int DIV_MIN   = 2;
  localparam int CNT_W_DEF = 26;

  // Callers cast to and from 32 bits, so counters must be at most 32 bits wide.
  function automatic logic [31:0] ceil_half(input logic [31:0] n);
    return (n >> 1) + {31'd0, n[0]};
  endfunction

  function automatic logic [31:0] clamp_div(input logic [31:0] n);
    return (n < 32'(DIV_MIN)) ? 32'(DIV_MIN) : n;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, pending flag, tick and square-wave registers.
// With CLKDIV_DUTY_EN defined, the square-wave high time is loaded alongside the divisor.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = 50_000_000
) (
  input  logic             CLK_50M,
  input  logic             nCLR,
  input  logic             i_en,
  input  logic             i_sync_clr,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_div,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0] i_hi,
`endif
  output logic             o_tick,
  output logic             o_sq,
  output logic             o_pending
);

  localparam logic [CNT_W-1:0] DEF_N = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(ceil_half(32'(DEF_DIV)));

  logic [CNT_W-1:0] r_cnt, r_div, r_shadow;
  logic             r_pending, r_tick, r_sq;
  logic             w_hold, w_wrap, w_apply, w_sq_nxt;
  logic [CNT_W-1:0] w_div_nxt, w_hi_nxt, w_cnt_nxt;
`ifdef CLKDIV_DUTY_EN
  logic [CNT_W-1:0] r_hi, r_shadow_hi;
`endif

  always_comb begin
    w_hold    = !i_en || i_sync_clr;
    w_wrap    = (r_cnt == r_div - CNT_W'(1));
    // The shadow only lands where the count restarts, so a period is never cut short.
    w_apply   = r_pending && (w_hold || w_wrap);
    w_div_nxt = w_apply ? r_shadow : r_div;
`ifdef CLKDIV_DUTY_EN
    w_hi_nxt  = w_apply ? r_shadow_hi : r_hi;
`else
    w_hi_nxt  = CNT_W'(ceil_half(32'(w_div_nxt)));
`endif
    w_cnt_nxt = (w_hold || w_wrap) ? '0 : r_cnt + CNT_W'(1);
    // Extra bit keeps cnt + H from wrapping when H >= N.
    w_sq_nxt  = !w_hold &&
                (({1'b0, w_cnt_nxt} + {1'b0, w_hi_nxt}) >= {1'b0, w_div_nxt});
  end

  always_ff @(posedge CLK_50M or negedge nCLR) begin
    if (!nCLR) begin
      r_cnt       <= '0;
      r_div       <= DEF_N;
      r_shadow    <= DEF_N;
      r_pending   <= 1'b0;
      r_tick      <= 1'b0;
      r_sq        <= 1'b0;
`ifdef CLKDIV_DUTY_EN
      r_hi        <= DEF_H;
      r_shadow_hi <= DEF_H;
`endif
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_div  <= w_div_nxt;
      r_tick <= !w_hold && w_wrap;
      r_sq   <= w_sq_nxt;
`ifdef CLKDIV_DUTY_EN
      r_hi   <= w_hi_nxt;
`endif
      // A write is only offered while nothing is pending, so it never meets an apply.
      if (i_wr) begin
        r_shadow    <= CNT_W'(clamp_div(32'(i_div)));
`ifdef CLKDIV_DUTY_EN
        r_shadow_hi <= i_hi;
`endif
        r_pending   <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_tick    = r_tick;
  assign o_sq      = r_sq;
  assign o_pending = r_pending;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel tick / square-wave generator from CLK_50M with runtime-loadable divisors.
// Define CLKDIV_DUTY_EN to add the cfg_hi high-time input.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = 50_000_000,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK_50M,
  input  logic              nCLR,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              cfg_valid,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
`ifdef CLKDIV_DUTY_EN
  input  logic [CNT_W-1:0]  cfg_hi,
`endif
  output logic              cfg_ready,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] sq_o,
  output logic [NUM_CH-1:0] div_pending
);

  logic [NUM_CH-1:0] w_wr;

  // Handshake: a write transfers on a clock edge where cfg_valid && cfg_ready.
  // cfg_ready is low while the addressed channel still holds an unapplied shadow;
  // an out-of-range cfg_ch is always ready and the write is dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) cfg_ready = !div_pending[i];
    end
  end

  always_comb begin
    w_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .CLK_50M    (CLK_50M),
      .nCLR       (nCLR),
      .i_en       (ch_en[g]),
      .i_sync_clr (sync_clr),
      .i_wr       (w_wr[g]),
      .i_div      (cfg_div),
`ifdef CLKDIV_DUTY_EN
      .i_hi       (cfg_hi),
`endif
      .o_tick     (tick_o[g]),
      .o_sq       (sq_o[g]),
      .o_pending  (div_pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi with DEF_DIV=4: a vector table plus per-channel sequences.
module tb_clk_div_multi;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 8;
  localparam int DEF_DIV = 4;

  logic             CLK_50M = 1'b0;
  logic             nCLR    = 1'b0;
  logic [3:0]       ch_en;
  logic             sync_clr;
  logic             cfg_valid;
  logic [1:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic [3:0]       tick_o, sq_o, div_pending;
`ifdef CLKDIV_DUTY_EN
  logic [CNT_W-1:0] cfg_hi;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] en;
    logic       sync;
    logic [3:0] tick;
    logic [3:0] sq;
  } vec_t;

  vec_t tbl[24];

  // clock / reset
  always #10 CLK_50M = ~CLK_50M;

  initial begin
    #100_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  clk_div_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .CLK_50M     (CLK_50M),
    .nCLR        (nCLR),
    .ch_en       (ch_en),
    .sync_clr    (sync_clr),
    .cfg_valid   (cfg_valid),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
`ifdef CLKDIV_DUTY_EN
    .cfg_hi      (cfg_hi),
`endif
    .cfg_ready   (cfg_ready),
    .tick_o      (tick_o),
    .sq_o        (sq_o),
    .div_pending (div_pending)
  );

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] en, input logic sync,
                              input logic [3:0] tick, input logic [3:0] sq);
    vec_t v;
    v.en = en; v.sync = sync; v.tick = tick; v.sq = sq;
    return v;
  endfunction

  // driver tasks
  task automatic set_hi(input logic [CNT_W-1:0] h);
`ifdef CLKDIV_DUTY_EN
    cfg_hi = h;
`else
    if (h == '1) $display("note: high time unused in this build");
`endif
  endtask

  // Leaves time just after an edge with reset released; the next posedge is edge 1.
  task automatic do_reset();
    nCLR      = 1'b0;
    ch_en     = 4'hF;
    cfg_valid = 1'b0;
    sync_clr  = 1'b0;
    @(posedge CLK_50M); #1;
    nCLR = 1'b1;
  endtask

  // 14-edge run on one channel; bit (14-k) of each mask belongs to edge k.
  task automatic run_seq(input string name, input int ch,
                         input logic [13:0] wr_mask, input logic [13:0] sync_mask,
                         input logic [CNT_W-1:0] div_a, input logic [CNT_W-1:0] div_b,
                         input logic [13:0] exp_tick, input logic [13:0] exp_sq,
                         input logic [13:0] exp_pend, input logic [13:0] exp_rdy);
    bit first = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      int b = 14 - k;
      cfg_valid = wr_mask[b];
      cfg_ch    = 2'(ch);
      cfg_div   = first ? div_a : div_b;
      sync_clr  = sync_mask[b];
      #1;
      if (wr_mask[b]) begin
        chk($sformatf("%s_rdy_e%0d", name, k), 32'(cfg_ready), 32'(exp_rdy[b]));
        first = 1'b0;
      end
      @(posedge CLK_50M); #1;
      cfg_valid = 1'b0;
      sync_clr  = 1'b0;
      chk($sformatf("%s_tick_e%0d", name, k), 32'(tick_o[ch]), 32'(exp_tick[b]));
      chk($sformatf("%s_sq_e%0d", name, k), 32'(sq_o[ch]), 32'(exp_sq[b]));
      chk($sformatf("%s_pend_e%0d", name, k), 32'(div_pending[ch]), 32'(exp_pend[b]));
    end
  endtask

  initial begin
    tbl[0]  = mk(4'hF, 1'b0, 4'h0, 4'h0);
    tbl[1]  = mk(4'hF, 1'b0, 4'h0, 4'hF);
    tbl[2]  = mk(4'hF, 1'b0, 4'h0, 4'hF);
    tbl[3]  = mk(4'hF, 1'b0, 4'hF, 4'h0);
    tbl[4]  = mk(4'hF, 1'b0, 4'h0, 4'h0);
    tbl[5]  = mk(4'hF, 1'b0, 4'h0, 4'hF);
    tbl[6]  = mk(4'hF, 1'b0, 4'h0, 4'hF);
    tbl[7]  = mk(4'hF, 1'b0, 4'hF, 4'h0);
    tbl[8]  = mk(4'hF, 1'b0, 4'h0, 4'h0);
    tbl[9]  = mk(4'hF, 1'b0, 4'h0, 4'hF);
    tbl[10] = mk(4'hF, 1'b0, 4'h0, 4'hF);
    tbl[11] = mk(4'hF, 1'b0, 4'hF, 4'h0);
    tbl[12] = mk(4'hF, 1'b0, 4'h0, 4'h0);
    tbl[13] = mk(4'h7, 1'b0, 4'h0, 4'h7);
    tbl[14] = mk(4'h7, 1'b0, 4'h0, 4'h7);
    tbl[15] = mk(4'hF, 1'b0, 4'h7, 4'h0);
    tbl[16] = mk(4'hF, 1'b0, 4'h0, 4'h8);
    tbl[17] = mk(4'hF, 1'b0, 4'h0, 4'hF);
    tbl[18] = mk(4'hF, 1'b0, 4'h8, 4'h7);
    tbl[19] = mk(4'hF, 1'b1, 4'h0, 4'h0);
    tbl[20] = mk(4'hF, 1'b0, 4'h0, 4'h0);
    tbl[21] = mk(4'hF, 1'b0, 4'h0, 4'hF);
    tbl[22] = mk(4'hF, 1'b0, 4'h0, 4'hF);
    tbl[23] = mk(4'hF, 1'b0, 4'hF, 4'h0);

    ch_en     = 4'hF;
    sync_clr  = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 2'd0;
    cfg_div   = '0;
    set_hi(8'd2);
    nCLR      = 1'b0;
    repeat (3) @(posedge CLK_50M);
    #1;
    chk("rst_tick", 32'(tick_o), 32'h0);
    chk("rst_sq", 32'(sq_o), 32'h0);
    chk("rst_pend", 32'(div_pending), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);
    nCLR = 1'b1;

    // Default period, ch3 disable/re-enable, then sync_clr realignment.
    for (int k = 0; k < 24; k++) begin
      ch_en    = tbl[k].en;
      sync_clr = tbl[k].sync;
      @(posedge CLK_50M); #1;
      chk($sformatf("tbl%0d_tick", k + 1), 32'(tick_o), 32'(tbl[k].tick));
      chk($sformatf("tbl%0d_sq", k + 1), 32'(sq_o), 32'(tbl[k].sq));
      chk($sformatf("tbl%0d_pend", k + 1), 32'(div_pending), 32'h0);
    end
    sync_clr = 1'b0;

    do_reset();
    set_hi(8'd3);
    run_seq("odd", 1, 14'b10000000000000, 14'b0, 8'd5, 8'd5,
            14'b00010000100001, 14'b01100111001110,
            14'b11100000000000, 14'b10000000000000);

    do_reset();
    set_hi(8'd5);
    run_seq("bp", 0, 14'b01111000000000, 14'b0, 8'd10, 8'd10,
            14'b00010000000001, 14'b01100000111110,
            14'b01101111111110, 14'b01001000000000);

    do_reset();
    set_hi(8'd1);
    run_seq("clamp", 2, 14'b00010000100000, 14'b0, 8'd0, 8'd1,
            14'b00010001010101, 14'b01100110101010,
            14'b00011110100000, 14'b00010000100000);

    do_reset();
    set_hi(8'd2);
    run_seq("sync", 3, 14'b10000000000000, 14'b01000000000000, 8'd3, 8'd3,
            14'b00001001001001, 14'b00110110110110,
            14'b10000000000000, 14'b10000000000000);

    // Asynchronous reset in mid-period drops a pending shadow.
    do_reset();
    cfg_valid = 1'b1;
    cfg_ch    = 2'd0;
    cfg_div   = 8'd10;
    @(posedge CLK_50M); #1;
    cfg_valid = 1'b0;
    chk("midrst_pend_before", 32'(div_pending), 32'h1);
    @(posedge CLK_50M); #1;
    chk("midrst_sq_before", 32'(sq_o), 32'hF);
    nCLR = 1'b0;
    #2;
    chk("midrst_sq", 32'(sq_o), 32'h0);
    chk("midrst_tick", 32'(tick_o), 32'h0);
    chk("midrst_pend", 32'(div_pending), 32'h0);
    @(posedge CLK_50M); #1;
    nCLR = 1'b1;
    run_seq("after_rst", 0, 14'b0, 14'b0, 8'd0, 8'd0,
            14'b00010001000100, 14'b01100110011001,
            14'b00000000000000, 14'b00000000000000);

`ifdef CLKDIV_DUTY_EN
    do_reset();
    set_hi(8'd3);
    run_seq("duty3", 0, 14'b10000000000000, 14'b0, 8'd10, 8'd10,
            14'b00010000000001, 14'b01100000001110,
            14'b11100000000000, 14'b10000000000000);

    do_reset();
    set_hi(8'd0);
    run_seq("duty0", 0, 14'b10000000000000, 14'b0, 8'd10, 8'd10,
            14'b00010000000001, 14'b01100000000000,
            14'b11100000000000, 14'b10000000000000);
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel clock/tick generator. Successor to the fixed 50 MHz to 1 Hz divider.
- NUM_CH independent channels run from CLK_50M. Each channel's divisor is loadable at runtime.
- Each channel outputs a single-cycle tick enable (for counters in the digital-clock datapath) and a registered square wave (for LEDs and display blink).
- Divisor changes are glitch-free: a new value takes effect only at a period boundary.

Parameters:
- NUM_CH, 4, number of independent divider channels.
- CNT_W, 26, counter and divisor width; must hold DEF_DIV.
- DEF_DIV, 50000000, reset divisor for every channel (1 Hz at 50 MHz).

Ports:
- CLK_50M  in  1  system clock.
- nCLR  in  1  reset, asynchronous, active-low. Reset nCLR, asynchronous, active-low; clock CLK_50M.
- ch_en  in  NUM_CH  per-channel run enable.
- sync_clr  in  1  synchronous restart of all channel counters.
- cfg_valid  in  1  divisor write request.
- cfg_ch  in  clog2(NUM_CH)  target channel.
- cfg_div  in  CNT_W  new divisor N (period in clocks).
- cfg_ready  out  1  write accepted when high together with cfg_valid.
- tick_o  out  NUM_CH  one-cycle pulse per period.
- sq_o  out  NUM_CH  square wave.
- div_pending  out  NUM_CH  shadow divisor waiting to apply.

Behaviour:
- Reset (async, nCLR=0):
  - all counts 0, active divisors = DEF_DIV.
  - tick_o=0, sq_o=0, div_pending=0, no shadow loaded.
- Counter, per enabled channel, on each edge:
  - if count==N-1: count<=0, tick<=1.
  - else: count<=count+1, tick<=0.
  - First tick appears in the cycle after edge N following reset release, then every N edges.
- Square wave: sq registered as (count_next >= N-H), with H=ceil(N/2).
  - High for the last H counts, low for the first floor(N/2) counts.
  - Falls on the same edge that tick rises.
- Disabled channel (ch_en[i]=0): count held at 0, tick=0, sq=0. Re-enable restarts from count 0.
- sync_clr=1: all counts<=0, tick<=0, sq<=0 on that edge. Overrides counting and wrap.
- Divisor clamp: N<2 is clamped to 2 on acceptance. N=2 gives a tick every 2nd cycle and sq toggling 1-on/1-off.
- Config handshake:
  - cfg_ready = !div_pending[cfg_ch] (combinational).
  - Accept when cfg_valid && cfg_ready: shadow[ch]<=clamped cfg_div, div_pending[ch]<=1.
  - cfg_ch >= NUM_CH: accepted and discarded; cfg_ready=1.
- Shadow apply:
  - Enabled channel: at the wrap edge (count==N-1), N<=shadow and pending<=0. The new period starts at count 0.
  - Disabled channel or sync_clr: applies on the next edge.
- Simultaneous events:
  - Accept on the same edge as a wrap: the new value does not apply at that wrap; it applies at the next one.
  - Reset mid-operation discards the shadow and pending flags.

Optional Feature:
- CLKDIV_DUTY_EN defined:
  - Adds input cfg_hi (CNT_W), accepted with cfg_div into a shadow high-time H.
  - sq is high for the last H counts.
  - H=0 gives sq constantly 0; H>=N gives sq high except when the channel is disabled or cleared.
  - Reset value of H = ceil(DEF_DIV/2).
- Undefined: H fixed at ceil(N/2); no cfg_hi port.

Decomposition:
- Package clk_div_pkg:
  - DIV_MIN=2, default CNT_W.
  - function ceil_half(N), function clamp_div(N).
- Sub-module clk_div_chan: one channel holding counter, active/shadow divisor, pending flag, tick/sq registers.
- Top level: generate loop over NUM_CH plus cfg_ch decode and cfg_ready mux.

Test Plan:
- Reset defaults: NUM_CH=4, DEF_DIV=4, all ch_en=1 after reset -> tick_o=0 and sq_o=0 during reset. Ticks in the cycles after edges 4, 8, 12. sq high for counts 2,3.
- Odd divisor: write N=5 to ch1 -> ch1 applies at the next wrap. Then tick every 5 cycles, sq high 3 cycles, low 2.
- Clamp: write N=0 and N=1 to ch2 -> behaves as N=2, tick every 2nd cycle.
- Back-pressure: write ch0 twice with N=10 before the wrap -> the second write sees cfg_ready=0 until the wrap; div_pending[0] is 1 then 0.
- Disable, sync, reset:
  - drop ch_en[3] mid-period -> tick/sq go 0, count resets; re-enable restarts the count at 0.
  - sync_clr pulse -> all channels realign, ticks coincident when divisors are equal.
  - nCLR low mid-period -> outputs 0 asynchronously and the pending shadow is lost.
- CLKDIV_DUTY_EN: N=10, cfg_hi=3 -> sq high for counts 7..9. cfg_hi=0 -> sq stays 0 while ticks continue every 10 cycles.
